// File: rtl/cal_pkg.sv
// Shared types, BCD digit constants and calendar helpers for bcd_calendar_clock.
// Leap and month-length rules work directly on packed BCD digits.
package cal_pkg;

   localparam int unsigned BCD_W = 4;

   localparam logic [BCD_W-1:0] ZERO  = 4'd0;
   localparam logic [BCD_W-1:0] ONE   = 4'd1;
   localparam logic [BCD_W-1:0] TWO   = 4'd2;
   localparam logic [BCD_W-1:0] THREE = 4'd3;
   localparam logic [BCD_W-1:0] FOUR  = 4'd4;
   localparam logic [BCD_W-1:0] FIVE  = 4'd5;
   localparam logic [BCD_W-1:0] SIX   = 4'd6;
   localparam logic [BCD_W-1:0] SEVEN = 4'd7;
   localparam logic [BCD_W-1:0] EIGHT = 4'd8;
   localparam logic [BCD_W-1:0] NINE  = 4'd9;

   // year is always 4 digits wide here; 2-digit builds leave the top byte zero
   typedef struct packed {
      logic [15:0] year;
      logic [7:0]  month;
      logic [7:0]  day;
      logic [7:0]  hour;
      logic [7:0]  min;
      logic [7:0]  sec;
   } cal_time_t;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      COMMIT
   } cal_state_t;

   // A two-digit number is a multiple of 4 iff even tens end in 0/4/8 or odd tens end in 2/6
   function automatic logic div4_bcd(input logic [7:0] v);
      if (v[4])
         return (v[3:0] == TWO) || (v[3:0] == SIX);
      return (v[3:0] == ZERO) || (v[3:0] == FOUR) || (v[3:0] == EIGHT);
   endfunction

   function automatic logic is_leap(input logic [15:0] year, input logic gregorian);
      if (!gregorian)
         return div4_bcd(year[7:0]);
      if (year[7:0] == 8'h00)
         return div4_bcd(year[15:8]);
      return div4_bcd(year[7:0]);
   endfunction

   function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                input logic [15:0] year,
                                                input logic gregorian);
      case (month)
         8'h02:                      return is_leap(year, gregorian) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   function automatic logic [15:0] bin_to_bcd16(input int unsigned value);
      int unsigned v;
      logic [15:0] r;
      v = value;
      r = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         r[i*BCD_W +: BCD_W] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed BCD counter with load, programmable min/max and wrap carry.
module bcd2_counter
   import cal_pkg::*;
#(
   parameter logic [7:0] RESET_VALUE = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_value,
   input  logic [7:0] min_value,
   input  logic [7:0] max_value,
   output logic [7:0] value,
   output logic       wrap
);

   logic [7:0] incremented;

   always_comb begin
      incremented = value;
      if (value[3:0] == NINE)
         incremented = {value[7:4] + 4'd1, ZERO};
      else
         incremented = {value[7:4], value[3:0] + 4'd1};
   end

   // load wins over inc, so a committed value never produces a carry
   assign wrap = inc && !load && (value == max_value);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value <= RESET_VALUE;
      else if (load)
         value <= load_value;
      else if (inc)
         value <= (value == max_value) ? min_value : incremented;
   end

endmodule

// File: rtl/bcd_calendar_clock.sv
// BCD calendar clock: tick-enabled sec..year chain with leap years and a validated set handshake.
// Optional alarm comparator enabled by defining CAL_ALARM_EN.
module bcd_calendar_clock
   import cal_pkg::*;
#(
   parameter int unsigned YEAR_DIGITS = 2,
   parameter int unsigned RESET_YEAR  = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tick,
   input  logic                        set_valid,
   output logic                        set_ready,
   input  logic [40+4*YEAR_DIGITS-1:0] set_time,
   output logic                        set_ack,
   output logic                        set_err,
   output logic [7:0]                  sec,
   output logic [7:0]                  min,
   output logic [7:0]                  hour,
   output logic [7:0]                  day,
   output logic [7:0]                  month,
   output logic [4*YEAR_DIGITS-1:0]    year,
`ifdef CAL_ALARM_EN
   input  logic                        alarm_set,
   input  logic [15:0]                 alarm_hhmm,
   output logic                        alarm,
`endif
   output logic                        year_wrap
);

   localparam int unsigned YEAR_W    = 4 * YEAR_DIGITS;
   localparam int unsigned TIME_W    = 40 + YEAR_W;
   localparam logic        GREGORIAN = (YEAR_DIGITS == 4);
   localparam logic [15:0] RESET_BCD = bin_to_bcd16(RESET_YEAR);

   cal_state_t        state, state_next;
   logic [TIME_W-1:0] shadow;
   cal_time_t         sh;
   logic              set_ok;
   logic              ack_next, err_next;
   logic              commit, tick_adv;
   logic              sec_c, min_c, hour_c, day_c, month_c, year_lo_c, year_carry;
   logic [7:0]        year_lo;
   logic [15:0]       year_ext;
   logic [7:0]        day_max;

   always_comb begin
      sh                   = '0;
      sh.sec               = shadow[7:0];
      sh.min               = shadow[15:8];
      sh.hour              = shadow[23:16];
      sh.day               = shadow[31:24];
      sh.month             = shadow[39:32];
      sh.year[YEAR_W-1:0]  = shadow[TIME_W-1:40];
   end

   // BCD ordering matches numeric ordering once every nibble is known to be <= 9
   always_comb begin
      set_ok = 1'b1;
      for (int unsigned i = 0; i < TIME_W / BCD_W; i++)
         if (shadow[i*BCD_W +: BCD_W] > NINE)
            set_ok = 1'b0;
      if (sh.sec > 8'h59 || sh.min > 8'h59 || sh.hour > 8'h23)
         set_ok = 1'b0;
      if (sh.month == 8'h00 || sh.month > 8'h12)
         set_ok = 1'b0;
      if (sh.day == 8'h00 || sh.day > days_in_month(sh.month, sh.year, GREGORIAN))
         set_ok = 1'b0;
   end

   always_comb begin
      state_next = state;
      ack_next   = 1'b0;
      err_next   = 1'b0;
      case (state)
         IDLE:
            if (set_valid)
               state_next = CHECK;
         CHECK:
            if (set_ok) begin
               state_next = COMMIT;
            end else begin
               err_next   = 1'b1;
               state_next = IDLE;
            end
         COMMIT: begin
            ack_next   = 1'b1;
            state_next = IDLE;
         end
         default:
            state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shadow    <= '0;
         set_ack   <= 1'b0;
         set_err   <= 1'b0;
         year_wrap <= 1'b0;
      end else begin
         state     <= state_next;
         set_ack   <= ack_next;
         set_err   <= err_next;
         year_wrap <= year_carry;
         if (state == IDLE && set_valid)
            shadow <= set_time;
      end
   end

   assign set_ready = (state == IDLE);
   assign commit    = (state == COMMIT);
   assign tick_adv  = tick && !commit;
   assign day_max   = days_in_month(month, year_ext, GREGORIAN);

   bcd2_counter #(.RESET_VALUE(8'h00)) u_sec (
      .clk(clk), .rst(rst), .inc(tick_adv), .load(commit), .load_value(sh.sec),
      .min_value(8'h00), .max_value(8'h59), .value(sec), .wrap(sec_c));

   bcd2_counter #(.RESET_VALUE(8'h00)) u_min (
      .clk(clk), .rst(rst), .inc(sec_c), .load(commit), .load_value(sh.min),
      .min_value(8'h00), .max_value(8'h59), .value(min), .wrap(min_c));

   bcd2_counter #(.RESET_VALUE(8'h00)) u_hour (
      .clk(clk), .rst(rst), .inc(min_c), .load(commit), .load_value(sh.hour),
      .min_value(8'h00), .max_value(8'h23), .value(hour), .wrap(hour_c));

   bcd2_counter #(.RESET_VALUE(8'h01)) u_day (
      .clk(clk), .rst(rst), .inc(hour_c), .load(commit), .load_value(sh.day),
      .min_value(8'h01), .max_value(day_max), .value(day), .wrap(day_c));

   bcd2_counter #(.RESET_VALUE(8'h01)) u_month (
      .clk(clk), .rst(rst), .inc(day_c), .load(commit), .load_value(sh.month),
      .min_value(8'h01), .max_value(8'h12), .value(month), .wrap(month_c));

   bcd2_counter #(.RESET_VALUE(RESET_BCD[7:0])) u_year_lo (
      .clk(clk), .rst(rst), .inc(month_c), .load(commit), .load_value(sh.year[7:0]),
      .min_value(8'h00), .max_value(8'h99), .value(year_lo), .wrap(year_lo_c));

   generate
      if (YEAR_DIGITS == 4) begin : g_year4
         logic [7:0] year_hi;
         logic       year_hi_c;

         bcd2_counter #(.RESET_VALUE(RESET_BCD[15:8])) u_year_hi (
            .clk(clk), .rst(rst), .inc(year_lo_c), .load(commit), .load_value(sh.year[15:8]),
            .min_value(8'h00), .max_value(8'h99), .value(year_hi), .wrap(year_hi_c));

         assign year       = {year_hi, year_lo};
         assign year_ext   = {year_hi, year_lo};
         assign year_carry = year_hi_c;
      end else begin : g_year2
         assign year       = year_lo;
         assign year_ext   = {8'h00, year_lo};
         assign year_carry = year_lo_c;
      end
   endgenerate

`ifdef CAL_ALARM_EN
   logic [15:0] alarm_time;
   logic        alarm_armed;
   logic        ticked;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alarm_time  <= '0;
         alarm_armed <= 1'b0;
         ticked      <= 1'b0;
      end else begin
         ticked <= tick_adv;
         if (alarm_set) begin
            alarm_time  <= alarm_hhmm;
            alarm_armed <= 1'b1;
         end
      end
   end

   // ticked excludes COMMIT, so a set landing on the alarm minute stays silent
   assign alarm = alarm_armed && ticked && (sec == 8'h00) && ({hour, min} == alarm_time);
`endif

endmodule

// File: doc/bcd_calendar_clock.md
Name: bcd_calendar_clock

Overview:
- Parametrised successor of the team's BCD sec/min/hour/day/month/year counter chain.
- Adds correct leap-year handling, a tick enable (no longer counts every clk), a validated set handshake and configurable year width.
- Sits between the 1 Hz tick generator and the 7-segment display scanner.
- All time outputs are packed BCD registers.

Parameters:
- YEAR_DIGITS, 2, number of BCD year digits; legal values 2 or 4.
- RESET_YEAR, 0, binary year loaded at reset; must be below 10**YEAR_DIGITS.

Ports:
- clk  in  1  global clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle advance strobe (1 Hz enable)
- set_valid  in  1  set request
- set_ready  out  1  block can accept a set
- set_time  in  40+4*YEAR_DIGITS  packed BCD {year,month,day,hour,min,sec}
- set_ack  out  1  one-cycle pulse: set committed
- set_err  out  1  one-cycle pulse: set rejected
- sec  out  8  BCD 00-59
- min  out  8  BCD 00-59
- hour  out  8  BCD 00-23
- day  out  8  BCD 01-31
- month  out  8  BCD 01-12
- year  out  4*YEAR_DIGITS  BCD year
- year_wrap  out  1  one-cycle pulse when year rolls max->0

Behaviour:
- Reset (async, rst=1):
  - sec/min/hour=00, day=01, month=01, year=BCD(RESET_YEAR).
  - set_ready=1; set_ack, set_err and year_wrap=0; FSM=IDLE.
- Advance: tick sampled high -> all fields update on the same clk edge (latency 1). No tick -> all fields hold.
- Rollover chain:
  - sec 59->00 carries to min; min 59->00 carries to hour; hour 23->00 carries to day.
  - day last->01 carries to month; month 12->01 carries to year.
- Days in month:
  - 31 for 01,03,05,07,08,10,12; 30 for 04,06,09,11; 28 for 02, or 29 when leap.
- Leap rule:
  - YEAR_DIGITS=2: year divisible by 4 (00 counts as leap, i.e. 2000-2099).
  - YEAR_DIGITS=4: Gregorian rule (div 4, not div 100 unless div 400).
  - Evaluated directly on BCD digits: no binary conversion.
- Year max (99 or 9999) -> 0: year_wrap pulses in the cycle after that edge, aligned with the outputs.
- Set FSM, three states IDLE/CHECK/COMMIT:
  - IDLE: set_ready=1. On set_valid capture set_time into a shadow register -> CHECK. set_ready=0 in every other state.
  - CHECK, one cycle. Valid only if every nibble <=9, sec/min<=59, hour<=23, month 01-12 and day 01..days_in_month(month,year).
    - Valid -> COMMIT.
    - Invalid -> set_err=1 for one cycle -> IDLE. Running time untouched.
  - COMMIT, one cycle: load shadow into the time registers, set_ack=1 -> IDLE.
  - COMMIT has priority over a tick on the same edge: the tick is dropped and the committed value appears exactly.
  - Ticks during IDLE/CHECK advance the running time normally.
- Reset mid-set: FSM returns to IDLE, shadow is discarded, no ack/err pulse.
- set_valid held across multiple requests: a new capture happens only on IDLE cycles.

Optional Feature:
- Macro: CAL_ALARM_EN.
- Defined:
  - Adds ports alarm_set (in 1), alarm_hhmm (in 16, BCD hour,min) and alarm (out 1).
  - alarm_set loads the alarm register (reset value 00:00, alarm disabled until the first load).
  - alarm pulses one cycle when a tick edge produces sec=00 with hour:min equal to the alarm value.
  - An alarm commit via set does not fire the alarm.
- Undefined: none of these ports, registers or comparator exist. All other behaviour is identical.

Decomposition:
- Package cal_pkg holds:
  - BCD_W=4 and BCD digit constants ZERO..NINE.
  - Packed typedef cal_time_t with fields sec/min/hour/day/month/year.
  - FSM state enum.
  - Functions days_in_month(month, year) and is_leap(year), both on BCD.
- One sub-module: bcd2_counter.
  - Two-digit BCD counter with inputs inc, load and load_value, plus min/max-value inputs.
  - Outputs value and a wrap-carry.
  - Instantiated per field, with the day max fed from days_in_month.

Test Plan:
- Reset then 61 ticks -> sec=01, min=01, hour=00, day=01, month=01, year=00.
- Set 2024-02-28 23:59:59 (YEAR_DIGITS=4), one tick -> 2024-02-29 00:00:00; set 2100-02-28 23:59:59, one tick -> 2100-03-01 00:00:00.
- Set year 99, 12-31 23:59:59 (YEAR_DIGITS=2), one tick -> 00-01-01 00:00:00 and year_wrap=1 for exactly one cycle.
- Set 2023-02-29 or sec=0x5A -> set_err pulse 2 cycles after accept, time unchanged, set_ack never asserted.
- Tick asserted on the COMMIT edge -> outputs equal set_time exactly; set_ready is low for 2 cycles and then returns high.
- With CAL_ALARM_EN: alarm 07:30, time 07:29:59, tick -> alarm=1 for one cycle; no tick -> alarm stays 0.
